// File: rtl/lsu_stage.sv
// Load/store stage: aligns store lanes, extracts/extends load data, and stalls the core
// across a request/grant/rvalid data-memory handshake. Optional trap: MISALIGN_TRAP_EN.
module lsu_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [2:0]        func_3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wmask,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        func_q, func_d;
  logic [1:0]        off_q, off_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [31:0]       dwdata_q, dwdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [31:0]       ldata_q, ldata_d;
  logic              lvalid_q, lvalid_d;
  logic              mis_q, mis_d;

  logic              illegal_c;
  logic [3:0]        lane_mask_c;
  logic [31:0]       lane_data_c;

  // Byte/half/word extraction with sign or zero extension
  function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] off,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      default: extract = d;
    endcase
  endfunction

  assign illegal_c = (func_3 == 3'b011) || (func_3[2:1] == 2'b11) || (mem_we && func_3[2]);

`ifdef MISALIGN_TRAP_EN
  logic misalign_c;
  assign misalign_c = ((func_3[1:0] == 2'b01) && addr[0]) ||
                      ((func_3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign misaligned = mis_q;
`endif

  // Store lane alignment; loads never write
  always_comb begin
    lane_mask_c = 4'b0000;
    lane_data_c = 32'd0;
    if (mem_we) begin
      case (func_3[1:0])
        2'b00: begin
          case (addr[1:0])
            2'd0:    lane_mask_c = 4'b0001;
            2'd1:    lane_mask_c = 4'b0010;
            2'd2:    lane_mask_c = 4'b0100;
            default: lane_mask_c = 4'b1000;
          endcase
          lane_data_c = {4{wdata[7:0]}};
        end
        2'b01: begin
          lane_mask_c = addr[1] ? 4'b1100 : 4'b0011;
          lane_data_c = {2{wdata[15:0]}};
        end
        default: begin
          lane_mask_c = 4'b1111;
          lane_data_c = wdata;
        end
      endcase
    end
  end

  assign stall = ((state_q == S_IDLE) && mem_en) || (state_q == S_REQ) || (state_q == S_WAIT);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    off_d    = off_q;
    req_d    = req_q;
    we_d     = we_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    wmask_d  = wmask_q;
    ldata_d  = ldata_q;
    lvalid_d = 1'b0;
    mis_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          if (illegal_c) begin
            state_d  = S_DONE;
            ldata_d  = 32'd0;
            lvalid_d = !mem_we;
          end
`ifdef MISALIGN_TRAP_EN
          else if (misalign_c) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end
`endif
          else begin
            state_d  = S_REQ;
            req_d    = 1'b1;
            func_d   = func_3;
            off_d    = addr[1:0];
            we_d     = mem_we;
            daddr_d  = {addr[ADDR_W-1:2], 2'b00};
            dwdata_d = lane_data_c;
            wmask_d  = lane_mask_c;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          ldata_d  = extract(func_q, off_q, dmem_rdata);
          lvalid_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      func_q   <= 3'd0;
      off_q    <= 2'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= 32'd0;
      wmask_q  <= 4'd0;
      ldata_q  <= 32'd0;
      lvalid_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      off_q    <= off_d;
      req_q    <= req_d;
      we_q     <= we_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      wmask_q  <= wmask_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
      mis_q    <= mis_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign dmem_wmask = wmask_q;
  assign load_data  = ldata_q;
  assign load_valid = lvalid_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: stores, loads, delayed handshakes, reset mid-access, misalignment.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  func_3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  lsu_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .func_3(func_3),
    .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    mem_en = 1'b1;
    mem_we = we;
    func_3 = f;
    addr   = a;
    wdata  = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; func_3 = 3'b000; addr = 32'd0;
    wdata = 32'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wmask", 32'(dmem_wmask), 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_lvalid", 32'(load_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_mis", 32'(misaligned), 32'd0);
`endif

    // SW 0x100, immediate grant
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw_stall_idle", 32'(stall), 32'd1);
    cyc(); dmem_gnt = 1'b1; #1;
    chk("sw_req", 32'(dmem_req), 32'd1);
    chk("sw_we", 32'(dmem_we), 32'd1);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_wmask", 32'(dmem_wmask), 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall_req", 32'(stall), 32'd1);
    cyc(); dmem_gnt = 1'b0; #1;
    chk("sw_stall_done", 32'(stall), 32'd0);
    chk("sw_req_drop", 32'(dmem_req), 32'd0);
    chk("sw_no_lvalid", 32'(load_valid), 32'd0);
    mem_en = 1'b0;
    cyc();
    chk("sw_idle_lvalid", 32'(load_valid), 32'd0);

    // SB 0x103
    issue(1'b1, 3'b000, 32'h103, 32'h000000A5);
    cyc();
    chk("sb_wmask", 32'(dmem_wmask), 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("sb_we", 32'(dmem_we), 32'd1);
    chk("sb_addr", dmem_addr, 32'h100);
    dmem_gnt = 1'b1;
    cyc(); dmem_gnt = 1'b0; mem_en = 1'b0;
    cyc();

    // LB then LBU at 0x102
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h102, 32'd0);
      cyc();
      chk("lb_req", 32'(dmem_req), 32'd1);
      chk("lb_we", 32'(dmem_we), 32'd0);
      chk("lb_wmask", 32'(dmem_wmask), 32'd0);
      chk("lb_addr", dmem_addr, 32'h100);
      dmem_gnt = 1'b1;
      cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12803456; #1;
      chk("lb_wait_stall", 32'(stall), 32'd1);
      chk("lb_wait_req", 32'(dmem_req), 32'd0);
      cyc(); dmem_rvalid = 1'b0; #1;
      chk("lb_lvalid", 32'(load_valid), 32'd1);
      chk("lb_ldata", load_data, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      chk("lb_done_stall", 32'(stall), 32'd0);
      mem_en = 1'b0;
      cyc();
      chk("lb_lvalid_pulse", 32'(load_valid), 32'd0);
    end

    // LH 0x106, grant delayed 3 cycles, rvalid 2 cycles after grant
    issue(1'b0, 3'b001, 32'h106, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 3) dmem_gnt = 1'b1;
      #1;
      chk("lh_req_hold", 32'(dmem_req), 32'd1);
      chk("lh_addr_hold", dmem_addr, 32'h104);
      chk("lh_stall_req", 32'(stall), 32'd1);
    end
    cyc(); dmem_gnt = 1'b0; #1;
    chk("lh_req_drop", 32'(dmem_req), 32'd0);
    chk("lh_stall_w1", 32'(stall), 32'd1);
    cyc(); dmem_rvalid = 1'b1; dmem_rdata = 32'h80017FFF; #1;
    chk("lh_stall_w2", 32'(stall), 32'd1);
    cyc(); dmem_rvalid = 1'b0; #1;
    chk("lh_ldata", load_data, 32'hFFFF8001);
    chk("lh_lvalid", 32'(load_valid), 32'd1);
    chk("lh_done_stall", 32'(stall), 32'd0);
    mem_en = 1'b0;
    cyc();

    // Reset during WAIT, then stray rvalid and stray gnt
    issue(1'b0, 3'b010, 32'h200, 32'd0);
    cyc(); dmem_gnt = 1'b1;
    cyc(); dmem_gnt = 1'b0; rst = 1'b1; mem_en = 1'b0;
    cyc(); rst = 1'b0; #1;
    chk("rst_wait_req", 32'(dmem_req), 32'd0);
    chk("rst_wait_stall", 32'(stall), 32'd0);
    dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    cyc(); dmem_rvalid = 1'b0; dmem_gnt = 1'b0; #1;
    chk("stray_lvalid", 32'(load_valid), 32'd0);
    chk("stray_ldata", load_data, 32'd0);
    chk("stray_req", 32'(dmem_req), 32'd0);
    cyc();
    chk("stray_lvalid2", 32'(load_valid), 32'd0);

    // Illegal store func_3 skips memory
    issue(1'b1, 3'b100, 32'h300, 32'h1);
    cyc(); #1;
    chk("ill_req", 32'(dmem_req), 32'd0);
    chk("ill_stall", 32'(stall), 32'd0);
    mem_en = 1'b0;
    cyc();

    // LW 0x101
    issue(1'b0, 3'b010, 32'h101, 32'd0);
`ifdef MISALIGN_TRAP_EN
    cyc();
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_flag", 32'(misaligned), 32'd1);
    chk("mis_lvalid", 32'(load_valid), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    mem_en = 1'b0;
    cyc();
    chk("mis_pulse", 32'(misaligned), 32'd0);
`else
    cyc();
    chk("lw_req", 32'(dmem_req), 32'd1);
    chk("lw_addr", dmem_addr, 32'h100);
    dmem_gnt = 1'b1;
    cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    cyc(); dmem_rvalid = 1'b0; #1;
    chk("lw_ldata", load_data, 32'hCAFEF00D);
    chk("lw_lvalid", 32'(load_valid), 32'd1);
    mem_en = 1'b0;
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
